// File: rtl/isqrt_pkg.sv
// Shared types and elaboration helpers for the digit-by-digit integer square-root unit.
package isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Clock cycles spent in CALC: one bit-pair per iteration, BPC iterations per cycle.
   function automatic int unsigned calc_iters(input int unsigned width, input int unsigned bpc);
      return width / (2 * bpc);
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned bpc);
      return (width >= 4) && ((width % 2) == 0) && ((bpc == 1) || (bpc == 2)) &&
             (((width / 2) % bpc) == 0);
   endfunction

endpackage

// File: rtl/isqrt_if.sv
// Request/result valid-ready channel pair for the square-root unit.
interface isqrt_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH/2-1:0]   out_root;
   logic [WIDTH/2:0]     out_rem;
   logic                 out_error;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_root, out_rem, out_error
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_root, out_rem, out_error
   );
endinterface

// File: rtl/isqrt_step.sv
// One combinational restoring iteration: shift in a radicand bit-pair and resolve one root bit.
module isqrt_step #(
   parameter int unsigned RW = 16
) (
   input  logic [RW+1:0] i_rem,
   input  logic [RW-1:0] i_root,
   input  logic [1:0]    i_pair,
   output logic [RW+1:0] o_rem,
   output logic [RW-1:0] o_root
);
   logic [RW+1:0] w_shift;
   logic [RW+1:0] w_trial;
   logic          w_ge;
   logic          w_unused;

   // Incoming remainder is always < 2^RW while more pairs remain, so its top two bits are zero.
   assign w_shift  = {i_rem[RW-1:0], i_pair};
   assign w_trial  = {i_root, 2'b01};
   assign w_ge     = (w_shift >= w_trial);
   assign o_rem    = w_ge ? (w_shift - w_trial) : w_shift;
   assign o_root   = {i_root[RW-2:0], w_ge};
   assign w_unused = ^i_rem[RW+1:RW];
endmodule

// File: rtl/isqrt_unit.sv
// Fixed-latency integer square root: floor(sqrt(x)) and x - root^2 behind valid/ready channels.
module isqrt_unit
   import isqrt_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter bit          SIGNED_IN      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   isqrt_if.slave     bus,
   output logic       busy
);
   localparam int unsigned RW = WIDTH / 2;
   localparam int unsigned N  = calc_iters(WIDTH, BITS_PER_CYCLE);
   localparam int unsigned CW = $clog2(N + 1);

   if (!cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
      $error("isqrt_unit: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_op;
   logic [RW+1:0]     r_rem;
   logic [RW-1:0]     r_root;
   logic [CW-1:0]     r_cnt;
   logic [RW-1:0]     r_out_root;
   logic [RW:0]       r_out_rem;
   logic              r_out_err;
   logic              w_neg;
   logic              w_last;

   logic [RW+1:0]     w_rem_c  [BITS_PER_CYCLE+1];
   logic [RW-1:0]     w_root_c [BITS_PER_CYCLE+1];

   assign w_rem_c[0]  = r_rem;
   assign w_root_c[0] = r_root;

   // Iterations chain MSB pair first; the operand is shifted left after each cycle.
   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      isqrt_step #(.RW(RW)) u_step (
         .i_rem  (w_rem_c[g]),
         .i_root (w_root_c[g]),
         .i_pair (r_op[WIDTH-1-2*g -: 2]),
         .o_rem  (w_rem_c[g+1]),
         .o_root (w_root_c[g+1])
      );
   end

   assign w_neg  = SIGNED_IN && bus.in_data[WIDTH-1];
   assign w_last = (r_cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) w_next = w_neg ? DONE : CALC;
         end
         CALC: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_rem      <= '0;
         r_root     <= '0;
         r_cnt      <= '0;
         r_out_root <= '0;
         r_out_rem  <= '0;
         r_out_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_op   <= bus.in_data;
                  r_rem  <= '0;
                  r_root <= '0;
                  r_cnt  <= CW'(N);
                  if (w_neg) begin
                     r_out_root <= '0;
                     r_out_rem  <= '0;
                     r_out_err  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_op   <= r_op << (2 * BITS_PER_CYCLE);
               r_rem  <= w_rem_c[BITS_PER_CYCLE];
               r_root <= w_root_c[BITS_PER_CYCLE];
               r_cnt  <= r_cnt - CW'(1);
               if (w_last) begin
                  r_out_root <= w_root_c[BITS_PER_CYCLE];
                  r_out_rem  <= w_rem_c[BITS_PER_CYCLE][RW:0];
                  r_out_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_root  = r_out_root;
   assign bus.out_rem   = r_out_rem;
   assign bus.out_error = r_out_err;
endmodule
